des_feistel_rounds: RTL

//  Iterative DES round engine: accepts the IP-permuted block halves (L0,R0), runs ROUNDS

---
 rtl/des_pkg.sv | 49 ++++
 rtl/des_round_function.sv | 32 +++
 rtl/des_feistel_rounds.sv | 109 ++++++++++
 3 files changed

// File: rtl/des_pkg.sv
// Shared DES types and tables for the iterative Feistel round engine.
// Bit numbering follows DES convention: index 1 is the MSB of every vector.
package des_pkg;

    typedef logic [1:32] half_t;
    typedef logic [1:48] subkey_t;

    localparam int DES_ROUNDS = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ROUND = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    // Expansion E: output bit i takes input bit E_TAB[i].
    localparam int E_TAB [1:48] = '{
        32,  1,  2,  3,  4,  5,  4,  5,  6,  7,  8,  9,
         8,  9, 10, 11, 12, 13, 12, 13, 14, 15, 16, 17,
        16, 17, 18, 19, 20, 21, 20, 21, 22, 23, 24, 25,
        24, 25, 26, 27, 28, 29, 28, 29, 30, 31, 32,  1
    };

    // Permutation P: output bit i takes S-box output bit P_TAB[i].
    localparam int P_TAB [1:32] = '{
        16,  7, 20, 21, 29, 12, 28, 17,  1, 15, 23, 26,  5, 18, 31, 10,
         2,  8, 24, 14, 32, 27,  3,  9, 19, 13, 30,  6, 22, 11,  4, 25
    };

    // S-boxes S1..S8, four rows each; a row packs 16 nibbles, column 0 in the top nibble.
    localparam logic [63:0] S_TAB [1:8][0:3] = '{
        '{64'hE4D12FB83A6C5907, 64'h0F74E2D1A6CB9538, 64'h41E8D62BFC973A50, 64'hFC8249175B3EA06D},
        '{64'hF18E6B34972DC05A, 64'h3D47F28EC01A69B5, 64'h0E7BA4D158C6932F, 64'hD8A13F42B67C05E9},
        '{64'hA09E63F51DC7B428, 64'hD709346A285ECBF1, 64'hD6498F30B12C5AE7, 64'h1AD069874FE3B52C},
        '{64'h7DE3069A1285BC4F, 64'hD8B56F03472C1AE9, 64'hA690CB7DF13E5284, 64'h3F06A1D8945BC72E},
        '{64'h2C417AB6853FD0E9, 64'hEB2C47D150FA3986, 64'h421BAD78F9C5630E, 64'hB8C71E2D6F09A453},
        '{64'hC1AF92680D34E75B, 64'hAF427C9561DE0B38, 64'h9EF528C3704A1DB6, 64'h432C95FABE17608D},
        '{64'h4B2EF08D3C975A61, 64'hD0B7491AE35C2F86, 64'h14BDC37EAF680592, 64'h6BD814A7950FE23C},
        '{64'hD2846FB1A93E50C7, 64'h1FD8A374C56B0E92, 64'h7B419CE206ADF358, 64'h21E74A8DFC90356B}
    };

    // Select column col (0..15) from a packed S-box row; ~col*4 is the shift to the LSBs.
    function automatic logic [3:0] sbox_pick(input logic [63:0] line, input logic [3:0] col);
        logic [63:0] sh;
        sh = line >> {~col, 2'b00};
        return sh[3:0];
    endfunction

endpackage

// File: rtl/des_round_function.sv
// DES cipher function f(R,K) = P(S(E(R) ^ K)); purely combinational.
module des_round_function
    import des_pkg::*;
(
    input  logic [1:32] r,
    input  logic [1:48] k,
    output logic [1:32] f
);

    logic [1:48] e_x;    // E(r) ^ k
    logic [1:32] s_out;  // concatenated S1..S8 outputs

    genvar gi;

    for (gi = 1; gi <= 48; gi++) begin : g_expand
        assign e_x[gi] = r[E_TAB[gi]] ^ k[gi];
    end

    // Each S-box consumes six bits: outer bits pick the row, inner four the column.
    for (gi = 1; gi <= 8; gi++) begin : g_sbox
        logic [1:6]  six;
        logic [63:0] line;
        assign six  = e_x[6*gi-5 : 6*gi];
        assign line = S_TAB[gi][{six[1], six[6]}];
        assign s_out[4*gi-3 : 4*gi] = sbox_pick(line, six[2:5]);
    end

    for (gi = 1; gi <= 32; gi++) begin : g_perm
        assign f[gi] = s_out[P_TAB[gi]];
    end

endmodule

// File: rtl/des_feistel_rounds.sv
// Iterative DES round engine: one Feistel round per clock over ROUNDS rounds.
// Takes IP-permuted halves (L0,R0), returns the swapped pre-output (R16,L16).
// Subkeys are fetched combinationally from an external store via round_idx.
module des_feistel_rounds
    import des_pkg::*;
#(
    parameter int ROUNDS = DES_ROUNDS
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:32] in_left,
    input  logic [1:32] in_right,
    input  logic        decrypt,
    output logic [3:0]  round_idx,
    input  logic [1:48] subkey,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [1:32] out_left,
    output logic [1:32] out_right
);

    localparam logic [3:0] LAST_CNT = 4'(ROUNDS - 1);

    state_e      state_q, state_d;
    logic [1:32] l_q, l_d;
    logic [1:32] r_q, r_d;
    logic [3:0]  cnt_q, cnt_d;
    logic        dec_q, dec_d;
    logic [1:32] f_val;
    logic        accept;
    logic        last_round;

    assign accept     = (state_q == ST_IDLE) && in_valid;
    assign last_round = (cnt_q == LAST_CNT);

    des_round_function u_round_function (
        .r (r_q),
        .k (subkey),
        .f (f_val)
    );

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state: one block in flight; DONE waits for the downstream handshake
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (in_valid)   state_d = ST_ROUND;
            ST_ROUND: if (last_round) state_d = ST_DONE;
            ST_DONE:  if (out_ready)  state_d = ST_IDLE;
            default:                  state_d = ST_IDLE;
        endcase
    end

    // Datapath next-state: capture on accept, one round per ROUND cycle, hold otherwise
    always_comb begin
        l_d   = l_q;
        r_d   = r_q;
        cnt_d = cnt_q;
        dec_d = dec_q;
        if (accept) begin
            l_d   = in_left;
            r_d   = in_right;
            dec_d = decrypt;
            cnt_d = '0;
        end else if (state_q == ST_ROUND) begin
            l_d = r_q;
            r_d = l_q ^ f_val;
            // Counter parks on the last round so it never wraps past ROUNDS-1.
            if (!last_round) begin
                cnt_d = cnt_q + 4'd1;
            end
        end
    end

    // Datapath registers; cleared on reset so an aborted block leaves nothing behind
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            l_q   <= '0;
            r_q   <= '0;
            cnt_q <= '0;
            dec_q <= 1'b0;
        end else begin
            l_q   <= l_d;
            r_q   <= r_d;
            cnt_q <= cnt_d;
            dec_q <= dec_d;
        end
    end

    // Outputs: all derived from registers; the final swap is just the port mapping
    always_comb begin
        in_ready  = (state_q == ST_IDLE);
        out_valid = (state_q == ST_DONE);
        round_idx = dec_q ? (LAST_CNT - cnt_q) : cnt_q;
        out_left  = r_q;
        out_right = l_q;
    end

endmodule
